// File: rtl/moving_avg_ctrl.sv
// Moving-average datapath controller: input gating, in-flight tracking and
// safe reconfiguration. Define MOVING_AVG_CTRL_AUTO_DIV_EN to derive the divisor from the window length.
module moving_avg_ctrl #(
    parameter int MAX_LEN      = 255,
    parameter int MAX_INFLIGHT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [31:0]                  cfg_divisor,
    input  logic                         cfg_stb,
    output logic                         cfg_busy,
    input  logic                         up_tvalid,
    input  logic                         up_tlast,
    output logic                         up_tready,
    output logic                         dp_tvalid,
    input  logic                         dp_tready,
    input  logic                         dn_tvalid,
    input  logic                         dn_tready,
    output logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic [31:0]                  divisor,
    output logic                         clear
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_EOP = 2'd1,
        DRAIN    = 2'd2,
        CLEAR    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic            pkt_active_q, pkt_active_d;
    logic [LW-1:0]   sh_len_q, sh_len_d;
    logic [31:0]     sh_div_q, sh_div_d;
    logic [LW-1:0]   len_q, len_d;
    logic [31:0]     div_q, div_d;
    logic            clear_q;
    logic            busy_q;
    logic            open_s;
    logic            in_beat_s;
    logic            out_beat_s;

    // A zero-length window is meaningless and the upper bound keeps the datapath buffer in range.
    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] v);
        if (v == '0) begin
            sat_len = LW'(1);
        end else if (32'(v) > 32'(MAX_LEN)) begin
            sat_len = LW'(MAX_LEN);
        end else begin
            sat_len = v;
        end
    endfunction

    assign open_s     = ((state_q == RUN) || (state_q == WAIT_EOP)) &&
                        (inflight_q < IW'(MAX_INFLIGHT));
    assign dp_tvalid  = up_tvalid & open_s;
    assign up_tready  = dp_tready & open_s;
    assign in_beat_s  = up_tvalid & up_tready;
    assign out_beat_s = dn_tvalid & dn_tready;

    assign cfg_busy = busy_q;
    assign len      = len_q;
    assign divisor  = div_q;
    assign clear    = clear_q;

    // In-flight counter and packet tracking
    always_comb begin
        inflight_d   = inflight_q;
        pkt_active_d = pkt_active_q;
        if (in_beat_s && !out_beat_s) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!in_beat_s && out_beat_s && (inflight_q != '0)) begin
            inflight_d = inflight_q - IW'(1);
        end else begin
            inflight_d = inflight_q;
        end
        if (in_beat_s) begin
            pkt_active_d = ~up_tlast;
        end else begin
            pkt_active_d = pkt_active_q;
        end
    end

    // Reconfiguration FSM, shadow capture and config output load
    always_comb begin
        state_d  = state_q;
        sh_len_d = sh_len_q;
        sh_div_d = sh_div_q;
        len_d    = len_q;
        div_d    = div_q;
        case (state_q)
            RUN: begin
                if (cfg_stb) begin
                    sh_len_d = sat_len(cfg_len);
`ifdef MOVING_AVG_CTRL_AUTO_DIV_EN
                    sh_div_d = 32'(sat_len(cfg_len));
`else
                    sh_div_d = cfg_divisor;
`endif
                    // Next-state packet flag covers a packet opening or closing this cycle.
                    if (pkt_active_d) begin
                        state_d = WAIT_EOP;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            WAIT_EOP: begin
                if (in_beat_s && up_tlast) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT_EOP;
                end
            end
            DRAIN: begin
                if (inflight_d == '0) begin
                    state_d = CLEAR;
                end else begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (state_d == CLEAR) begin
            len_d = sh_len_q;
            div_d = sh_div_q;
        end else begin
            len_d = len_q;
            div_d = div_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            inflight_q   <= '0;
            pkt_active_q <= 1'b0;
            sh_len_q     <= LW'(MAX_LEN);
            sh_div_q     <= 32'(MAX_LEN);
            len_q        <= LW'(MAX_LEN);
            div_q        <= 32'(MAX_LEN);
            clear_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            pkt_active_q <= pkt_active_d;
            sh_len_q     <= sh_len_d;
            sh_div_q     <= sh_div_d;
            len_q        <= len_d;
            div_q        <= div_d;
            clear_q      <= (state_d == CLEAR);
            busy_q       <= (state_d != RUN);
        end
    end

endmodule

// File: tb/tb_moving_avg_ctrl.sv
// Directed self-checking bench for moving_avg_ctrl; a second instance with
// MAX_LEN=200 exercises upper-bound length saturation.
module tb_moving_avg_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cfg_len;
    logic [31:0] cfg_divisor;
    logic        cfg_stb;
    logic        up_tvalid, up_tlast, dp_tready, dn_tvalid, dn_tready;
    logic        cfg_busy, up_tready, dp_tvalid, clear;
    logic [7:0]  len;
    logic [31:0] divisor;
    logic        cfg_busy2, up_tready2, dp_tvalid2, clear2;
    logic [7:0]  len2;
    logic [31:0] divisor2;

    integer checks   = 0;
    integer failures = 0;

    always #5 clk = ~clk;

    moving_avg_ctrl dut (
        .clk(clk), .reset(reset), .cfg_len(cfg_len), .cfg_divisor(cfg_divisor),
        .cfg_stb(cfg_stb), .cfg_busy(cfg_busy), .up_tvalid(up_tvalid),
        .up_tlast(up_tlast), .up_tready(up_tready), .dp_tvalid(dp_tvalid),
        .dp_tready(dp_tready), .dn_tvalid(dn_tvalid), .dn_tready(dn_tready),
        .len(len), .divisor(divisor), .clear(clear)
    );

    moving_avg_ctrl #(.MAX_LEN(200), .MAX_INFLIGHT(64)) dut2 (
        .clk(clk), .reset(reset), .cfg_len(cfg_len), .cfg_divisor(cfg_divisor),
        .cfg_stb(cfg_stb), .cfg_busy(cfg_busy2), .up_tvalid(1'b0),
        .up_tlast(1'b0), .up_tready(up_tready2), .dp_tvalid(dp_tvalid2),
        .dp_tready(1'b0), .dn_tvalid(1'b0), .dn_tready(1'b0),
        .len(len2), .divisor(divisor2), .clear(clear2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_len = 8'd0; cfg_divisor = 32'd0; cfg_stb = 1'b0;
        up_tvalid = 1'b0; up_tlast = 1'b0; dp_tready = 1'b1;
        dn_tvalid = 1'b0; dn_tready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (len !== 8'd255) begin failures++; $display("FAIL rst_len actual=%0d expected=255", len); end
        checks++; if (divisor !== 32'd255) begin failures++; $display("FAIL rst_divisor actual=%0d expected=255", divisor); end
        checks++; if (clear !== 1'b0) begin failures++; $display("FAIL rst_clear actual=%0b expected=0", clear); end
        checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%0b expected=0", cfg_busy); end
        checks++; if (up_tready !== 1'b1) begin failures++; $display("FAIL rst_up_tready actual=%0b expected=1", up_tready); end
        checks++; if (dp_tvalid !== 1'b0) begin failures++; $display("FAIL rst_dp_tvalid actual=%0b expected=0", dp_tvalid); end
        checks++; if (len2 !== 8'd200) begin failures++; $display("FAIL rst_len2 actual=%0d expected=200", len2); end
        tick();
    endtask

    task automatic test_idle_reconfig();
        cfg_len = 8'd16; cfg_divisor = 32'd16; cfg_stb = 1'b1;
        tick();
        cfg_stb = 1'b0;
        checks++; if (clear !== 1'b0) begin failures++; $display("FAIL idle_clear_c1 actual=%0b expected=0", clear); end
        checks++; if (cfg_busy !== 1'b1) begin failures++; $display("FAIL idle_busy_c1 actual=%0b expected=1", cfg_busy); end
        checks++; if (len !== 8'd255) begin failures++; $display("FAIL idle_len_c1 actual=%0d expected=255", len); end
        tick();
        checks++; if (clear !== 1'b1) begin failures++; $display("FAIL idle_clear_c2 actual=%0b expected=1", clear); end
        checks++; if (len !== 8'd16) begin failures++; $display("FAIL idle_len_c2 actual=%0d expected=16", len); end
        checks++; if (divisor !== 32'd16) begin failures++; $display("FAIL idle_div_c2 actual=%0d expected=16", divisor); end
        tick();
        checks++; if (clear !== 1'b0) begin failures++; $display("FAIL idle_clear_c3 actual=%0b expected=0", clear); end
        checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL idle_busy_c3 actual=%0b expected=0", cfg_busy); end
    endtask

    task automatic test_packet_reconfig();
        logic [31:0] exp_div;
`ifdef MOVING_AVG_CTRL_AUTO_DIV_EN
        exp_div = 32'd32;
`else
        exp_div = 32'd5;
`endif
        dn_tvalid = 1'b0; dn_tready = 1'b0; dp_tready = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            up_tvalid = 1'b1;
            up_tlast  = (b == 8);
            if (b == 3) begin cfg_stb = 1'b1; cfg_len = 8'd32; cfg_divisor = 32'd5; end
            if (b == 5) begin cfg_stb = 1'b1; cfg_len = 8'd8;  cfg_divisor = 32'd9; end
            #1;
            checks++; if (up_tready !== 1'b1) begin failures++; $display("FAIL pkt_ready beat=%0d actual=%0b expected=1", b, up_tready); end
            tick();
            cfg_stb = 1'b0;
        end
        up_tlast = 1'b0;
        #1;
        checks++; if (up_tready !== 1'b0) begin failures++; $display("FAIL pkt_closed_after_tlast actual=%0b expected=0", up_tready); end
        checks++; if (dp_tvalid !== 1'b0) begin failures++; $display("FAIL pkt_dp_tvalid_closed actual=%0b expected=0", dp_tvalid); end
        checks++; if (cfg_busy !== 1'b1) begin failures++; $display("FAIL pkt_busy actual=%0b expected=1", cfg_busy); end
        up_tvalid = 1'b0;
        dn_tvalid = 1'b1; dn_tready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                checks++; if (clear !== 1'b0) begin failures++; $display("FAIL pkt_clear_early outbeat=%0d actual=%0b expected=0", k, clear); end
            end else begin
                checks++; if (clear !== 1'b1) begin failures++; $display("FAIL pkt_clear_after_drain actual=%0b expected=1", clear); end
                checks++; if (len !== 8'd32) begin failures++; $display("FAIL pkt_len_busy_ignored actual=%0d expected=32", len); end
                checks++; if (divisor !== exp_div) begin failures++; $display("FAIL pkt_divisor actual=%0d expected=%0d", divisor, exp_div); end
            end
        end
        dn_tvalid = 1'b0; dn_tready = 1'b0;
        tick();
        checks++; if (clear !== 1'b0) begin failures++; $display("FAIL pkt_clear_one_cycle actual=%0b expected=0", clear); end
        checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL pkt_busy_end actual=%0b expected=0", cfg_busy); end
    endtask

    task automatic test_inflight_limit();
        int accepted;
        accepted = 0;
        dn_tvalid = 1'b1; dn_tready = 1'b0;
        up_tvalid = 1'b1; up_tlast = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (up_tready === 1'b1) accepted++;
            tick();
        end
        checks++; if (accepted !== 64) begin failures++; $display("FAIL lim_accepted actual=%0d expected=64", accepted); end
        #1;
        checks++; if (up_tready !== 1'b0) begin failures++; $display("FAIL lim_closed actual=%0b expected=0", up_tready); end
        tick();
        checks++; if (up_tready !== 1'b0) begin failures++; $display("FAIL lim_still_closed actual=%0b expected=0", up_tready); end
        dn_tready = 1'b1;
        #1;
        checks++; if (up_tready !== 1'b0) begin failures++; $display("FAIL lim_closed_during_dn actual=%0b expected=0", up_tready); end
        tick();
        dn_tready = 1'b0;
        #1;
        checks++; if (up_tready !== 1'b1) begin failures++; $display("FAIL lim_resume actual=%0b expected=1", up_tready); end
        tick();
        checks++; if (up_tready !== 1'b0) begin failures++; $display("FAIL lim_refull actual=%0b expected=0", up_tready); end
        dn_tready = 1'b1;
        tick(); tick(); tick();
        checks++; if (up_tready !== 1'b1) begin failures++; $display("FAIL lim_both_beats_hold actual=%0b expected=1", up_tready); end
        up_tvalid = 1'b0; up_tlast = 1'b0;
        for (int i = 0; i < 70; i++) tick();
        dn_tvalid = 1'b0; dn_tready = 1'b0;
        #1;
        checks++; if (up_tready !== 1'b1) begin failures++; $display("FAIL lim_no_underflow actual=%0b expected=1", up_tready); end
    endtask

    task automatic test_saturation();
        logic [31:0] exp_div2;
`ifdef MOVING_AVG_CTRL_AUTO_DIV_EN
        exp_div2 = 32'd200;
`else
        exp_div2 = 32'd3;
`endif
        cfg_len = 8'd0; cfg_divisor = 32'd4; cfg_stb = 1'b1;
        tick();
        cfg_stb = 1'b0;
        tick();
        checks++; if (clear !== 1'b1) begin failures++; $display("FAIL sat_zero_clear actual=%0b expected=1", clear); end
        checks++; if (len !== 8'd1) begin failures++; $display("FAIL sat_zero_len actual=%0d expected=1", len); end
        checks++; if (len2 !== 8'd1) begin failures++; $display("FAIL sat_zero_len2 actual=%0d expected=1", len2); end
        tick();
        cfg_len = 8'd250; cfg_divisor = 32'd3; cfg_stb = 1'b1;
        tick();
        cfg_stb = 1'b0;
        tick();
        checks++; if (len !== 8'd250) begin failures++; $display("FAIL sat_inrange_len actual=%0d expected=250", len); end
        checks++; if (len2 !== 8'd200) begin failures++; $display("FAIL sat_max_len2 actual=%0d expected=200", len2); end
        checks++; if (divisor2 !== exp_div2) begin failures++; $display("FAIL sat_div2 actual=%0d expected=%0d", divisor2, exp_div2); end
        tick();
    endtask

    task automatic test_auto_div();
        logic [31:0] exp_div;
`ifdef MOVING_AVG_CTRL_AUTO_DIV_EN
        exp_div = 32'd10;
`else
        exp_div = 32'd7;
`endif
        cfg_len = 8'd10; cfg_divisor = 32'd7; cfg_stb = 1'b1;
        tick();
        cfg_stb = 1'b0;
        tick();
        checks++; if (divisor !== exp_div) begin failures++; $display("FAIL auto_div actual=%0d expected=%0d", divisor, exp_div); end
        checks++; if (len !== 8'd10) begin failures++; $display("FAIL auto_div_len actual=%0d expected=10", len); end
        tick();
    endtask

    task automatic test_reset_in_drain();
        dn_tvalid = 1'b1; dn_tready = 1'b0;
        up_tvalid = 1'b1; up_tlast = 1'b1;
        tick(); tick(); tick();
        up_tvalid = 1'b0; up_tlast = 1'b0;
        cfg_len = 8'd20; cfg_divisor = 32'd20; cfg_stb = 1'b1;
        tick();
        cfg_stb = 1'b0;
        #1;
        checks++; if (cfg_busy !== 1'b1) begin failures++; $display("FAIL rd_busy actual=%0b expected=1", cfg_busy); end
        checks++; if (up_tready !== 1'b0) begin failures++; $display("FAIL rd_drain_closed actual=%0b expected=0", up_tready); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (len !== 8'd255) begin failures++; $display("FAIL rd_len actual=%0d expected=255", len); end
        checks++; if (divisor !== 32'd255) begin failures++; $display("FAIL rd_divisor actual=%0d expected=255", divisor); end
        checks++; if (clear !== 1'b0) begin failures++; $display("FAIL rd_clear actual=%0b expected=0", clear); end
        checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL rd_busy_rst actual=%0b expected=0", cfg_busy); end
        checks++; if (up_tready !== 1'b1) begin failures++; $display("FAIL rd_open actual=%0b expected=1", up_tready); end
        tick(); tick(); tick();
        checks++; if (clear !== 1'b0) begin failures++; $display("FAIL rd_discarded_clear actual=%0b expected=0", clear); end
        checks++; if (len !== 8'd255) begin failures++; $display("FAIL rd_discarded_len actual=%0d expected=255", len); end
        dn_tvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_reconfig();
        test_packet_reconfig();
        test_inflight_limit();
        test_saturation();
        test_auto_div();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
